fnd_scan_controller: RTL and testbench

Parametrised multiplexed 7-segment (FND) display controller for N digits. A load strobe captures a binary value, which an iterative shift-add-3 (double-dabble) engine converts to BCD over several cycles; the result is double-buffered and scanned across the digits by a programmable tick divider. Adds per-digit decimal points, overflow indication, a busy/pending handshake and optional leading-zero blanking. It sits between the MicroBlaze GPIO/AXI register and the board's common-anode display pins.

---
 rtl/fnd_scan_controller.sv | 192 +++++++++++++++++++
 tb/tb_fnd_scan_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_controller.sv
// Multiplexed 7-segment scan controller with an iterative double-dabble converter.
// Define FND_LZB_EN to enable leading-zero blanking.
module fnd_scan_controller #(
    parameter int DIGITS   = 4,
    parameter int VALUE_W  = 14,
    parameter int TICK_DIV = 100000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [VALUE_W-1:0] i_value,
    input  logic [DIGITS-1:0]  i_dp,
    output logic               o_busy,
    output logic [DIGITS-1:0]  o_fndSelect,
    output logic [7:0]         o_fndFont,
    output logic [1:0]         o_dbg_state
);
    // Handshake: i_load is a fire-and-forget strobe with no backpressure; o_busy only
    // reports that a conversion is running or queued. A load arriving while busy
    // goes to a one-deep pending slot where the newest request overwrites older ones.

    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int CNT_W  = $clog2(VALUE_W);
    localparam int BCD_W  = 4 * DIGITS;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    function automatic logic seg_ovf(input logic [VALUE_W-1:0] v);
        return 64'(v) > MAX_VAL;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_COMMIT = 2'd2} state_t;
    state_t state, state_nxt;

    logic [VALUE_W-1:0] work_bin, pend_value, src_value;
    logic [BCD_W-1:0]   work_bcd, bcd_adj, disp_bcd;
    logic [DIGITS-1:0]  work_dp, pend_dp, src_dp, disp_dp, blank;
    logic               work_ovf, disp_ovf, pend_valid, start;
    logic [CNT_W-1:0]   shift_cnt;
    logic [TICK_W-1:0]  tick_cnt;
    logic [IDX_W-1:0]   digit_idx;
    logic               tick, scan_upd;
    logic [3:0]         cur_nib;
    logic               cur_dp;
    logic [7:0]         glyph;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (i_load || pend_valid) state_nxt = ST_SHIFT;
            ST_SHIFT:  if (shift_cnt == CNT_W'(VALUE_W - 1)) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = (i_load || pend_valid) ? ST_SHIFT : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (state != ST_IDLE);
        o_dbg_state = state;
    end

    // A queued value always goes ahead of a load arriving in the same cycle.
    always_comb begin
        start     = ((state == ST_IDLE) || (state == ST_COMMIT)) && (i_load || pend_valid);
        src_value = pend_valid ? pend_value : i_value;
        src_dp    = pend_valid ? pend_dp : i_dp;
    end

    always_comb begin
        bcd_adj = work_bcd;
        for (int i = 0; i < DIGITS; i++)
            if (work_bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = work_bcd[4*i +: 4] + 4'd3;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            work_bin   <= '0;
            work_bcd   <= '0;
            work_dp    <= '0;
            work_ovf   <= 1'b0;
            shift_cnt  <= '0;
            pend_valid <= 1'b0;
            pend_value <= '0;
            pend_dp    <= '0;
            disp_bcd   <= '0;
            disp_dp    <= '0;
            disp_ovf   <= 1'b0;
        end else begin
            if (start) begin
                work_bin  <= src_value;
                work_bcd  <= '0;
                work_dp   <= src_dp;
                work_ovf  <= seg_ovf(src_value);
                shift_cnt <= '0;
            end else if (state == ST_SHIFT) begin
                work_bcd  <= {bcd_adj[BCD_W-2:0], work_bin[VALUE_W-1]};
                work_bin  <= {work_bin[VALUE_W-2:0], 1'b0};
                shift_cnt <= shift_cnt + CNT_W'(1);
            end
            if (i_load && !(start && !pend_valid)) begin
                pend_valid <= 1'b1;
                pend_value <= i_value;
                pend_dp    <= i_dp;
            end else if (start) begin
                pend_valid <= 1'b0;
            end
            if (state == ST_COMMIT) begin
                disp_bcd <= work_bcd;
                disp_dp  <= work_dp;
                disp_ovf <= work_ovf;
            end
        end
    end

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    // scan_upd resets high so the first edge after release already drives digit 0.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tick_cnt  <= '0;
            digit_idx <= '0;
            scan_upd  <= 1'b1;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            scan_upd <= tick;
            if (tick) digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
        end
    end

`ifdef FND_LZB_EN
    logic lead;
    always_comb begin
        blank = '0;
        lead  = 1'b1;
        for (int n = DIGITS - 1; n >= 1; n--) begin
            lead     = lead && (disp_bcd[4*n +: 4] == 4'd0) && !disp_dp[n];
            blank[n] = lead;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        cur_nib = disp_bcd[4*digit_idx +: 4];
        cur_dp  = disp_dp[digit_idx];
        if (disp_ovf)             glyph = 8'hBF;
        else if (blank[digit_idx]) glyph = 8'hFF;
        else if (cur_nib > 4'd9)  glyph = 8'hFF;
        else                      glyph = {~cur_dp, seg7(cur_nib)};
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_fndSelect <= '1;
            o_fndFont   <= 8'hFF;
        end else if (scan_upd) begin
            o_fndSelect <= ~(DIGITS'(1) << digit_idx);
            o_fndFont   <= glyph;
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller: scan rotation, conversion results,
// overflow, pending-load replacement and asynchronous reset mid-conversion.
module tb_fnd_scan_controller;
    localparam int DIGITS   = 4;
    localparam int VALUE_W  = 14;
    localparam int TICK_DIV = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic [13:0]  value = '0;
    logic [3:0]   dp = '0;
    logic         busy;
    logic [3:0]   sel;
    logic [7:0]   font;
    logic [1:0]   dbg_state;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [13:0] value;
        logic [3:0]  dp;
        logic [31:0] fonts;
    } vec_t;
    vec_t vecs[8];

    fnd_scan_controller #(.DIGITS(DIGITS), .VALUE_W(VALUE_W), .TICK_DIV(TICK_DIV)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_load(load), .i_value(value), .i_dp(dp),
        .o_busy(busy), .o_fndSelect(sel), .o_fndFont(font), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [13:0] v, input logic [3:0] d);
        @(negedge clk);
        value = v;
        dp    = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic read_digit(input int n, output logic [7:0] f);
        logic [3:0] want;
        int t;
        want = ~(4'(1) << n);
        t = 0;
        while (sel !== want && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (sel !== want) begin
            checks++;
            failures++;
            $display("FAIL digit_select_timeout: got %b expected %b", sel, want);
        end
        f = font;
    endtask

    task automatic push_fonts(input logic [31:0] fonts);
        for (int i = 3; i >= 0; i--) exp_q.push_back(fonts[8*i +: 8]);
    endtask

    task automatic check_display(input string name);
        logic [7:0] f, e;
        for (int i = 3; i >= 0; i--) begin
            read_digit(i, f);
            e = exp_q.pop_front();
            check($sformatf("%s_digit%0d", name, i), 32'(f), 32'(e));
        end
    endtask

    initial begin
        int n;
        logic [3:0] want_sel;

        vecs[0] = '{14'd1234,  4'b0000, 32'hF9A4B099};
        vecs[1] = '{14'd10000, 4'b0000, 32'hBFBFBFBF};
        vecs[2] = '{14'd9999,  4'b0000, 32'h90909090};
        vecs[3] = '{14'd0,     4'b1111, 32'h40404040};
        vecs[4] = '{14'd16383, 4'b1010, 32'hBFBFBFBF};
        vecs[5] = '{14'd807,   4'b1000, 32'h4080C0F8};
`ifdef FND_LZB_EN
        vecs[6] = '{14'd5,     4'b0010, 32'hFFFF4092};
        vecs[7] = '{14'd60,    4'b0000, 32'hFFFF82C0};
`else
        vecs[6] = '{14'd5,     4'b0010, 32'hC0C04092};
        vecs[7] = '{14'd60,    4'b0000, 32'hC0C082C0};
`endif

        repeat (3) @(negedge clk);
        check("reset_select", 32'(sel), 32'hF);
        check("reset_font", 32'(font), 32'hFF);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);

        rst_n = 1'b1;
        for (int j = 1; j <= 17; j++) begin
            @(negedge clk);
            want_sel = ~(4'(1) << (((j - 1) / 4) % 4));
            check($sformatf("scan_select_c%0d", j), 32'(sel), 32'(want_sel));
            if (j == 1) check("first_font", 32'(font), 32'hC0);
        end

        // Busy window for a single conversion.
        do_load(14'd1234, 4'b0000);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("busy_len_single", 32'(n), 32'(VALUE_W + 1));
        repeat (20) @(negedge clk);
        push_fonts(32'hF9A4B099);
        check_display("single_1234");

        for (int v = 0; v < 8; v++) begin
            do_load(vecs[v].value, vecs[v].dp);
            wait_idle($sformatf("vec%0d_idle", v));
            repeat (20) @(negedge clk);
            push_fonts(vecs[v].fonts);
            check_display($sformatf("vec%0d", v));
        end

        // 42 then 7 on consecutive edges while busy: 7 replaces 42 in the pending slot.
        @(negedge clk);
        value = 14'd5;
        dp    = 4'b0000;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            if (busy) n++;
            if (c == 1) begin
                value = 14'd42;
                load  = 1'b1;
            end
            if (c == 2) value = 14'd7;
            if (c == 3) load = 1'b0;
            @(negedge clk);
        end
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("busy_len_pending", 32'(n), 32'(2 * (VALUE_W + 1)));
        repeat (20) @(negedge clk);
`ifdef FND_LZB_EN
        push_fonts(32'hFFFFFFF8);
`else
        push_fonts(32'hC0C0C0F8);
`endif
        check_display("pending_0007");

        // Asynchronous reset during SHIFT with a load pending.
        do_load(14'd1234, 4'b0000);
        repeat (3) @(negedge clk);
        value = 14'd42;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_select", 32'(sel), 32'hF);
        check("async_reset_font", 32'(font), 32'hFF);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'd0);
`ifdef FND_LZB_EN
        push_fonts(32'hFFFFFFC0);
`else
        push_fonts(32'hC0C0C0C0);
`endif
        check_display("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
